// File: rtl/execute_cycle.sv
// RV32 Execute stage: operand forwarding, ALU, BEQ resolution, branch target and the E/M register.
// Define EXEC_MUL_EN to add the iterative shift-add multiplier (ALUControlE = 110) that stalls the front end.
module execute_cycle #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic                  ResultSrcE,
  input  logic                  BranchE,
  input  logic                  ALUSrcE,
  input  logic [2:0]            ALUControlE,
  input  logic [DATA_W-1:0]     RD1_E,
  input  logic [DATA_W-1:0]     RD2_E,
  input  logic [DATA_W-1:0]     Imm_Ext_E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic [DATA_W-1:0]     PCE,
  input  logic [DATA_W-1:0]     PCPlus4E,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic [DATA_W-1:0]     ResultW,
  output logic                  PCSrcE,
  output logic [DATA_W-1:0]     PCTargetE,
  output logic                  BusyE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic                  ResultSrcM,
  output logic [REG_ADDR_W-1:0] RD_M,
  output logic [DATA_W-1:0]     PCPlus4M,
  output logic [DATA_W-1:0]     WriteDataM,
  output logic [DATA_W-1:0]     ALU_ResultM
);

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] alu_result;

  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALU_ResultM;
      default: fwd_b = RD2_E;
    endcase
    src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
  end

  // The multiply code yields 0 here; its product only ever reaches E/M from the FSM.
  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b100:  alu_result = src_a ^ src_b;
      3'b101:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign PCSrcE    = BranchE & (alu_result == '0);
  assign PCTargetE = PCE + Imm_Ext_E;

  logic              busy_raw;
  logic              mul_done;
  logic [DATA_W-1:0] mul_acc;
  logic [DATA_W-1:0] mul_wd;

`ifdef EXEC_MUL_EN
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

  mul_state_t        state;
  mul_state_t        state_next;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [CNT_W-1:0]  cnt;
  logic              mul_start;

  assign mul_start = (state == IDLE) && (ALUControlE == 3'b110);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_raw   = 1'b0;
    mul_done   = 1'b0;
    case (state)
      IDLE: begin
        if (mul_start) begin
          busy_raw   = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        busy_raw = 1'b1;
        if (cnt == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        mul_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands are captured at issue because the forwarding sources move on while we iterate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
      mul_wd  <= '0;
      cnt     <= '0;
    end else if (mul_start) begin
      mul_a   <= src_a;
      mul_b   <= src_b;
      mul_acc <= '0;
      mul_wd  <= fwd_b;
      cnt     <= '0;
    end else if (state == BUSY) begin
      mul_acc <= mul_acc + (mul_b[0] ? mul_a : '0);
      mul_a   <= mul_a << 1;
      mul_b   <= mul_b >> 1;
      cnt     <= cnt + CNT_W'(1);
    end
  end

  // Gated so a held multiply opcode cannot raise the stall while reset is asserted.
  assign BusyE = busy_raw & rst_n;
`else
  assign busy_raw = 1'b0;
  assign mul_done = 1'b0;
  assign mul_acc  = '0;
  assign mul_wd   = '0;
  assign BusyE    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else if (busy_raw) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= mul_done ? mul_wd  : fwd_b;
      ALU_ResultM <= mul_done ? mul_acc : alu_result;
    end
  end

endmodule
